// File: rtl/rle_pixel_decoder.sv
// Run-length pixel decoder: a small prefetch FIFO feeds a run expander that emits one
// colour per active pixel, with in-band end-of-row / end-of-frame commands.
module rle_pixel_decoder #(
   parameter int  COLOUR_BITS = 6,
   parameter int  RUN_BITS    = 10,
   parameter int  FIFO_DEPTH  = 4,
   localparam int DATA_WIDTH  = COLOUR_BITS + RUN_BITS
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [DATA_WIDTH-1:0]       in_data,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic                        next_frame,
   input  logic                        next_row,
   input  logic                        pixel_en,
   output logic [COLOUR_BITS-1:0]      colour,
   output logic                        fetch_restart,
   output logic                        fetch_stop,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level,
   output logic                        underflow,
   output logic                        desync
);

   localparam int PTR_BITS   = $clog2(FIFO_DEPTH);
   localparam int LEVEL_BITS = PTR_BITS + 1;

   localparam logic [PTR_BITS-1:0]    PTR_ONE    = PTR_BITS'(1);
   localparam logic [LEVEL_BITS-1:0]  LEVEL_ONE  = LEVEL_BITS'(1);
   localparam logic [LEVEL_BITS-1:0]  FULL_LEVEL = LEVEL_BITS'(FIFO_DEPTH);
   localparam logic [RUN_BITS-1:0]    REM_ONE    = RUN_BITS'(1);
   localparam logic [COLOUR_BITS-1:0] CMD_EOL    = '0;
   localparam logic [COLOUR_BITS-1:0] CMD_EOF    = COLOUR_BITS'(1);

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      RUN,
      EOL_WAIT,
      EOF_WAIT
   } state_t;

   logic [DATA_WIDTH-1:0]  mem [FIFO_DEPTH];
   logic [PTR_BITS-1:0]    rd_ptr;
   logic [PTR_BITS-1:0]    wr_ptr;
   logic [LEVEL_BITS-1:0]  count;
   logic                   fifo_empty;
   logic                   push;
   logic                   pop;
   logic                   flush;
   logic [DATA_WIDTH-1:0]  head;
   logic [RUN_BITS-1:0]    head_run;
   logic [COLOUR_BITS-1:0] head_col;

   state_t                 state_q, state_d;
   logic [RUN_BITS-1:0]    remaining_q, remaining_d;
   logic [COLOUR_BITS-1:0] colour_d;
   logic                   underflow_d, desync_d;
   logic                   restart_d, stop_d;
   logic                   load_head;

   assign in_ready   = (count < FULL_LEVEL);
   assign fifo_level = count;
   assign fifo_empty = (count == '0);
   assign flush      = next_frame;
   // A push coinciding with next_frame would land in a FIFO that is being flushed.
   assign push       = in_valid && in_ready && !next_frame;
   assign head       = mem[rd_ptr];
   assign head_run   = head[DATA_WIDTH-1:COLOUR_BITS];
   assign head_col   = head[COLOUR_BITS-1:0];

   // NOTE: the storage array has no reset; only pointers and count define what is valid.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= in_data;
      end
   end

   // NOTE: sequential state is assigned with <= so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         case ({push, pop})
            2'b10:   count <= count + LEVEL_ONE;
            2'b01:   count <= count - LEVEL_ONE;
            default: count <= count;
         endcase
      end
   end

   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      state_d     = state_q;
      colour_d    = colour;
      remaining_d = remaining_q;
      underflow_d = underflow;
      desync_d    = desync;
      restart_d   = 1'b0;
      stop_d      = 1'b0;
      load_head   = 1'b0;
      pop         = 1'b0;

      if (next_frame) begin
         state_d     = LOAD;
         colour_d    = '0;
         remaining_d = '0;
         underflow_d = 1'b0;
         desync_d    = 1'b0;
         restart_d   = 1'b1;
      end else begin
         if (next_row) begin
            if (state_q == EOL_WAIT) begin
               state_d = LOAD;
            end else if (state_q == LOAD || state_q == RUN) begin
               desync_d = 1'b1;
            end
         end

         case (state_q)
            LOAD: begin
               if (!fifo_empty) begin
                  load_head = 1'b1;
               end else if (pixel_en) begin
                  underflow_d = 1'b1;
               end
            end
            RUN: begin
               if (pixel_en) begin
                  if (remaining_q == REM_ONE) begin
                     // Last pixel of the run: chain straight into the next word if one is waiting.
                     if (!fifo_empty) begin
                        load_head = 1'b1;
                     end else begin
                        state_d = LOAD;
                     end
                  end else begin
                     remaining_d = remaining_q - REM_ONE;
                  end
               end
            end
            default: ;
         endcase

         if (load_head) begin
            pop = 1'b1;
            if (head_run != '0) begin
               colour_d    = head_col;
               remaining_d = head_run;
               state_d     = RUN;
            end else if (head_col == CMD_EOL) begin
               colour_d = '0;
               state_d  = EOL_WAIT;
            end else if (head_col == CMD_EOF) begin
               colour_d = '0;
               state_d  = EOF_WAIT;
               stop_d   = 1'b1;
            end else begin
               state_d = LOAD;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         colour        <= '0;
         remaining_q   <= '0;
         underflow     <= 1'b0;
         desync        <= 1'b0;
         fetch_restart <= 1'b0;
         fetch_stop    <= 1'b0;
      end else begin
         state_q       <= state_d;
         colour        <= colour_d;
         remaining_q   <= remaining_d;
         underflow     <= underflow_d;
         desync        <= desync_d;
         fetch_restart <= restart_d;
         fetch_stop    <= stop_d;
      end
   end

endmodule
